// File: rtl/axi_lite_csr_slave.sv
// AXI-Lite slave terminating all five channels into a bank of NUM_REGS CSRs.
// RW registers are byte-strobe writable; RO registers read back hw_status.
module axi_lite_csr_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic                           awFull_q, wFull_q;
  logic [ADDR_WIDTH-1:0]          awAddr_q;
  logic [DATA_WIDTH-1:0]          wData_q;
  logic [BYTES-1:0]               wStrb_q;
  logic                           bvalid_q;
  logic [1:0]                     bresp_q, bresp_d;
  logic                           rvalid_q;
  logic [1:0]                     rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            wrPulse_q, wrPulse_d;
  logic                           commit;
  logic [ADDR_WIDTH-1:0]          wrIdx, rdIdx;
  logic                           wrInRange, rdInRange;

  assign awready  = !awFull_q;
  assign wready   = !wFull_q;
  assign arready  = !rvalid_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;
  assign reg_out  = regs_q;
  assign wr_pulse = wrPulse_q;

  // A held write may only commit once the previous response has been taken.
  assign commit    = awFull_q && wFull_q && !bvalid_q;
  assign wrIdx     = awAddr_q >> OFFS;
  assign rdIdx     = araddr >> OFFS;
  assign wrInRange = wrIdx < ADDR_WIDTH'(NUM_REGS);
  assign rdInRange = rdIdx < ADDR_WIDTH'(NUM_REGS);

  always_comb begin
    regs_d    = regs_q;
    wrPulse_d = '0;
    bresp_d   = bresp_q;
    if (commit) begin
      bresp_d = wrInRange ? OKAY : SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrIdx == ADDR_WIDTH'(i)) begin
          wrPulse_d[i] = 1'b1;
          if (!RO_MASK[i]) begin
            for (int b = 0; b < BYTES; b++) begin
              if (wStrb_q[b]) begin
                regs_d[i*DATA_WIDTH + b*8 +: 8] = wData_q[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    rresp_d = rdInRange ? OKAY : SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rdIdx == ADDR_WIDTH'(i)) begin
        rdata_d = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH]
                             : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // RO slots are never written, so they are held at zero in reg_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awFull_q  <= 1'b0;
      wFull_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      wrPulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i*DATA_WIDTH +: DATA_WIDTH] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      regs_q    <= regs_d;
      wrPulse_q <= wrPulse_d;
      bresp_q   <= bresp_d;
      if (commit) begin
        awFull_q <= 1'b0;
        wFull_q  <= 1'b0;
      end else begin
        if (awvalid && !awFull_q) begin
          awFull_q <= 1'b1;
          awAddr_q <= awaddr;
        end
        if (wvalid && !wFull_q) begin
          wFull_q <= 1'b1;
          wData_q <= wdata;
          wStrb_q <= wstrb;
        end
      end
      if (commit) begin
        bvalid_q <= 1'b1;
      end else if (bvalid_q && bready) begin
        bvalid_q <= 1'b0;
      end
      if (arvalid && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (rvalid_q && rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Scoreboard bench for axi_lite_csr_slave: drivers push expected responses from a
// register-array model, negedge monitors pop and compare on each B/R handshake.
`timescale 1ns/1ps
module tb_axi_lite_csr_slave;

  localparam int NREG = 16;
  localparam logic [NREG-1:0] RO = 16'h0020;
  localparam logic [NREG*32-1:0] RST_VAL = (512'hA5A5_0000 << 96) | (512'h0000_1111 << 224)
                                         | (512'hCAFE_F00D << 0);

  typedef struct {
    logic [1:0]   resp;
    logic [511:0] regs;
    int           pulseIdx;
  } wexp_t;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic         clk = 0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [511:0] reg_out, hw_status;
  logic [15:0]  wr_pulse;

  logic [31:0] mdl[NREG];
  logic [31:0] hwMdl[NREG];
  wexp_t       wq[$];
  rexp_t       rq[$];
  int          pulseCnt[NREG];
  int          checks = 0;
  int          errors = 0;
  bit          randReady = 0, bHold = 0, rHold = 0;

  axi_lite_csr_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .RO_MASK(RO), .RESET_VAL(RST_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .hw_status(hw_status), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  always_comb begin
    hw_status = '0;
    for (int i = 0; i < NREG; i++) hw_status[i*32 +: 32] = hwMdl[i];
  end

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] packModel();
    logic [511:0] p = '0;
    for (int i = 0; i < NREG; i++) p[i*32 +: 32] = mdl[i];
    return p;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NREG; i++) mdl[i] = RO[i] ? 32'h0 : RST_VAL[i*32 +: 32];
  endtask

  // Ready lines change just after the rising edge so monitors see them settled.
  initial begin
    bready = 1;
    rready = 1;
    forever begin
      @(posedge clk);
      #1;
      bready = bHold ? 1'b0 : (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
      rready = rHold ? 1'b0 : (randReady ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  initial begin : bMonitor
    wexp_t e;
    logic [16:0] act, exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < NREG; i++) pulseCnt[i] = 0;
      end else begin
        for (int i = 0; i < NREG; i++) if (wr_pulse[i]) pulseCnt[i]++;
        if (bvalid) begin
          if (wq.size() == 0) begin
            checkOutput("b_unexpected", 1, 0);
          end else begin
            checkOutput("bresp", bresp, wq[0].resp);
            if (bready) begin
              e = wq.pop_front();
              checkOutput("reg_out", reg_out, e.regs);
              act = '0;
              exp = '0;
              for (int i = 0; i < NREG; i++) begin
                if (pulseCnt[i] == 1) act[i] = 1'b1;
                if (pulseCnt[i] > 1) act[16] = 1'b1;
                pulseCnt[i] = 0;
              end
              if (e.pulseIdx >= 0) exp[e.pulseIdx] = 1'b1;
              checkOutput("wr_pulse", act, exp);
            end
          end
        end
      end
    end
  end

  initial begin : rMonitor
    rexp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid) begin
        if (rq.size() == 0) begin
          checkOutput("r_unexpected", 1, 0);
        end else begin
          e = rq[0];
          if (rready) void'(rq.pop_front());
          checkOutput("rdata", rdata, e.data);
          checkOutput("rresp", rresp, e.resp);
        end
      end
    end
  end

  task automatic driveAw(input logic [31:0] a);
    bit done = 0;
    awaddr = a;
    awvalid = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (awready) begin @(posedge clk); #1; done = 1; end
    end
    awvalid = 0;
    if (!done) checkOutput("aw_timeout", 0, 1);
  endtask

  task automatic driveW(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (wready) begin @(posedge clk); #1; done = 1; end
    end
    wvalid = 0;
    if (!done) checkOutput("w_timeout", 0, 1);
  endtask

  task automatic driveAr(input logic [31:0] a);
    bit done = 0;
    araddr = a;
    arvalid = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (arready) begin @(posedge clk); #1; done = 1; end
    end
    arvalid = 0;
    if (!done) checkOutput("ar_timeout", 0, 1);
  endtask

  task automatic waitIdle();
    int c = 0;
    while ((wq.size() != 0 || rq.size() != 0) && c < 300) begin
      @(posedge clk);
      c++;
    end
    if (c >= 300) checkOutput("idle_timeout_pending", wq.size() + rq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // lead > 0: W goes lead cycles ahead of AW; lead < 0: AW goes first.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int lead, input bit waitDone);
    int unsigned idx = addr / 4;
    wexp_t we;
    rexp_t re;
    if (isWrite) begin
      we.resp = (idx < NREG) ? 2'b00 : 2'b10;
      we.pulseIdx = (idx < NREG) ? int'(idx) : -1;
      if (idx < NREG && !RO[idx]) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
      end
      we.regs = packModel();
      wq.push_back(we);
      fork
        begin
          if (lead > 0) begin
            repeat (lead) @(posedge clk);
            #1;
            checkOutput("wready_low_while_held", wready, 0);
          end
          driveAw(addr);
        end
        begin
          if (lead < 0) begin
            repeat (-lead) @(posedge clk);
            #1;
            checkOutput("awready_low_while_held", awready, 0);
          end
          driveW(data, strb);
        end
      join
    end else begin
      re.resp = (idx < NREG) ? 2'b00 : 2'b10;
      re.data = (idx >= NREG) ? 32'h0 : (RO[idx] ? hwMdl[idx] : mdl[idx]);
      rq.push_back(re);
      driveAr(addr);
    end
    if (waitDone) waitIdle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    logic [31:0] a;
    rst_n = 0;
    awvalid = 0; wvalid = 0; arvalid = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    for (int i = 0; i < NREG; i++) hwMdl[i] = $urandom;
    hwMdl[5] = 32'hDEAD_BEEF;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("awready_rst", awready, 1);
    checkOutput("wready_rst", wready, 1);
    checkOutput("arready_rst", arready, 1);
    checkOutput("bvalid_rst", bvalid, 0);
    checkOutput("rvalid_rst", rvalid, 0);
    checkOutput("wr_pulse_rst", wr_pulse, 0);
    checkOutput("reg_out_rst", reg_out, packModel());
    checkOutput("reg3_rst", reg_out[3*32 +: 32], 32'hA5A5_0000);
    applyStimulus(0, 32'h0C, 0, 0, 0, 1);

    $display("[TB] same-cycle AW+W");
    applyStimulus(1, 32'h08, 32'h1234_5678, 4'hF, 0, 0);
    checkOutput("bvalid_before_commit", bvalid, 0);
    @(posedge clk);
    #2;
    checkOutput("bvalid_after_commit", bvalid, 1);
    waitIdle();
    checkOutput("reg2_full", reg_out[2*32 +: 32], 32'h1234_5678);

    $display("[TB] partial strobe");
    applyStimulus(1, 32'h08, 32'hFFFF_FFFF, 4'h2, 0, 1);
    checkOutput("reg2_partial", reg_out[2*32 +: 32], 32'h1234_FF78);

    $display("[TB] W ahead of AW with B stall");
    bHold = 1;
    @(posedge clk);
    #2;
    applyStimulus(1, 32'h1C, 32'h0BAD_CAFE, 4'hF, 3, 0);
    c = 0;
    while (!bvalid && c < 50) begin @(posedge clk); #1; c++; end
    checkOutput("bvalid_stall_seen", bvalid, 1);
    applyStimulus(1, 32'h20, 32'h5566_7788, 4'h5, 0, 0);
    checkOutput("awready_during_stall", awready, 0);
    checkOutput("wready_during_stall", wready, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bvalid_still_held", bvalid, 1);
    bHold = 0;
    waitIdle();

    $display("[TB] out of range");
    applyStimulus(1, 32'h40, 32'h1111_2222, 4'hF, 0, 1);
    applyStimulus(0, 32'h40, 0, 0, 0, 1);

    $display("[TB] read-only register");
    applyStimulus(1, 32'h14, 32'h0, 4'hF, -2, 1);
    applyStimulus(0, 32'h14, 0, 0, 0, 1);

    $display("[TB] randomized traffic");
    randReady = 1;
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      applyStimulus($urandom_range(0, 1), a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 6) - 3, 1);
    end
    randReady = 0;
    waitIdle();

    $display("[TB] reset while read response held");
    rHold = 1;
    @(posedge clk);
    #2;
    applyStimulus(1, 32'h08, 32'h7777_7777, 4'hF, 0, 1);
    applyStimulus(0, 32'h14, 0, 0, 0, 0);
    c = 0;
    while (!rvalid && c < 50) begin @(posedge clk); #1; c++; end
    checkOutput("rvalid_before_reset", rvalid, 1);
    rst_n = 0;
    #1;
    checkOutput("rvalid_async_reset", rvalid, 0);
    checkOutput("arready_async_reset", arready, 1);
    rq.delete();
    wq.delete();
    resetModel();
    rHold = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    checkOutput("reg_out_after_reset", reg_out, packModel());
    applyStimulus(0, 32'h08, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
